lzc_normalizer_seq: RTL and testbench
=====================================

// Module: lzc_normalizer_seq
// PURPOSE
//  Sequential leading-zero count and left-normalize stage for a W-bit word.
//  Applies the 4-bit LZC function one nibble per cycle, scanning from the MSB.
//  Produces the normalized word, the total zero count and a zero flag.
//  Sits directly downstream of the 4-bit LZC (operators) and feeds later
//  fixed-to-float and normalization logic.
// PARAMETERS
//  W    16  data width; must be a multiple of 4, W >= 8
//  CW   5   count width; must satisfy 2**CW > W, so the count can hold W
// PORTS
//  clk         in   1   clock, rising edge
//  rst_n       in   1   asynchronous reset, active low
//  in_valid    in   1   in_data is valid
//  in_ready    out  1   block can accept a word (high only in IDLE)
//  in_data     in   W   word to normalize
//  out_valid   out  1   result is valid (high only in DONE)
//  out_ready   in   1   consumer accepts the result
//  norm_out    out  W   in_data << lz_count; 0 for a zero input
//  lz_count    out  CW  number of leading zeros, 0..W
//  zero_flag   out  1   in_data was all zeros
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//      - State goes to IDLE; the nibble index clears.
//      - Every output register clears to 0, so out_valid=0.
//      - in_ready=1 once rst_n=1.
//      - Reset during SCAN, SHIFT or DONE aborts the operation; the result is discarded.
//  - FSM states: IDLE, SCAN, SHIFT, DONE.
//  - IDLE (in_ready=1):
//      - When in_valid=1, the word is accepted at that edge (edge E0).
//      - The word goes into a data register; count=0; idx=0 (MSB nibble); next state SCAN.
//  - SCAN (one nibble per cycle). Nibble = data[W-1-4*idx -: 4].
//      - Nibble == 0 and not last: count += 4, idx++, stay in SCAN.
//      - Nibble == 0 and last nibble: count = W, zero_flag=1, norm_out=0, go to DONE.
//        SHIFT is skipped.
//      - Nibble != 0: count += lzc4(nibble), go to SHIFT.
//        lzc4 values: 1xxx->0, 01xx->1, 001x->2, 0001->3.
//        lzc4 is never applied to a zero nibble, so its 0000 output is unused.
//  - SHIFT (single cycle): norm_out <= data << count, lz_count <= count,
//    zero_flag <= 0, go to DONE.
//  - DONE:
//      - out_valid=1; norm_out, lz_count and zero_flag hold stable.
//      - When out_ready=1, go to IDLE at that edge; out_valid drops in the next cycle.
//  - Latency, with k = number of leading zero nibbles:
//      - Nonzero input: out_valid rises after edge E(k+2), where E0 is the acceptance edge.
//      - Zero input: out_valid rises after edge E(W/4).
//  - Handshake:
//      - in_valid while not in IDLE is ignored; the upstream holds the data.
//      - There is no IDLE->SCAN bypass. A new word is accepted no earlier than
//        the cycle after the DONE->IDLE handshake edge.
//  - Width rules:
//      - Shift is a logical left shift; zeros fill in; the result is truncated to W bits.
//      - count never exceeds W, so CW bits never overflow.
// TESTING  (W=16, CW=5)
//  - in=0x8000 -> norm_out=0x8000, lz_count=0, zero_flag=0; out_valid 2 cycles after acceptance.
//  - in=0x0001 -> norm_out=0x8000, lz_count=15, zero_flag=0; out_valid 5 cycles after acceptance.
//  - in=0x0350 -> norm_out=0xD400, lz_count=6, zero_flag=0; out_valid 3 cycles after acceptance.
//  - in=0x0000 -> norm_out=0x0000, lz_count=16, zero_flag=1; out_valid 4 cycles after acceptance.
//  - Backpressure: in=0x0F00 with out_ready=0 for 5 cycles in DONE.
//      - Outputs stay at 0x F000, 4 (norm_out=0xF000, lz_count=4).
//      - in_ready stays 0 and in_valid pulses are ignored.
//      - With out_ready=1 the block returns to IDLE; the next word 0x4000 -> lz_count=1.
//  - Reset: rst_n=0 mid-SCAN on in=0x0001 -> immediately out_valid=0 and all outputs 0.
//      - After release, in_ready=1; a fresh 0x2000 -> norm_out=0x8000, lz_count=2.

Source files
------------

// File: rtl/lzc_normalizer_seq_if.sv
// Handshake and result bus for the sequential leading-zero normalizer.
// The master side supplies words and accepts results; the slave side is the normalizer.
interface lzc_normalizer_seq_if #(
    parameter int unsigned W  = 16,
    parameter int unsigned CW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  norm_out;
    logic [CW-1:0] lz_count;
    logic          zero_flag;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, norm_out, lz_count, zero_flag
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, norm_out, lz_count, zero_flag
    );
endinterface

// File: rtl/lzc_normalizer_seq.sv
// Sequential leading-zero count and left-normalize: scans one nibble per cycle from the MSB,
// then shifts the word left by the total count in a single cycle.
module lzc_normalizer_seq #(
    parameter int unsigned W  = 16,
    parameter int unsigned CW = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    lzc_normalizer_seq_if.slave bus
);
    localparam int unsigned NN = W / 4;
    localparam int unsigned IW = (NN > 1) ? $clog2(NN) : 1;

    typedef enum logic [1:0] {StIdle, StScan, StShift, StDone} state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  data_q, data_d;
    logic [CW-1:0] count_q, count_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  norm_q, norm_d;
    logic [CW-1:0] lz_q, lz_d;
    logic          zf_q, zf_d;

    logic [W-1:0]  scan_word;
    logic [3:0]    nibble;
    logic          last_nibble;

    function automatic logic [1:0] lzc4(input logic [3:0] n);
        logic [1:0] r;
        unique casez (n)
            4'b1???: r = 2'd0;
            4'b01??: r = 2'd1;
            4'b001?: r = 2'd2;
            default: r = 2'd3;
        endcase
        return r;
    endfunction

    // Bring the current nibble to the top so the select stays a constant slice.
    assign scan_word   = data_q << {idx_q, 2'b00};
    assign nibble      = scan_word[W-1 -: 4];
    assign last_nibble = (idx_q == IW'(NN - 1));

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        idx_d   = idx_q;
        norm_d  = norm_q;
        lz_d    = lz_q;
        zf_d    = zf_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    count_d = '0;
                    idx_d   = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (nibble != 4'd0) begin
                    count_d = count_q + CW'(lzc4(nibble));
                    state_d = StShift;
                end else if (last_nibble) begin
                    count_d = CW'(W);
                    norm_d  = '0;
                    lz_d    = CW'(W);
                    zf_d    = 1'b1;
                    state_d = StDone;
                end else begin
                    count_d = count_q + CW'(4);
                    idx_d   = idx_q + IW'(1);
                end
            end
            StShift: begin
                norm_d  = data_q << count_q;
                lz_d    = count_q;
                zf_d    = 1'b0;
                state_d = StDone;
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            data_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
            norm_q  <= '0;
            lz_q    <= '0;
            zf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            norm_q  <= norm_d;
            lz_q    <= lz_d;
            zf_q    <= zf_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.norm_out  = norm_q;
    assign bus.lz_count  = lz_q;
    assign bus.zero_flag = zf_q;
endmodule

// File: tb/tb_lzc_normalizer_seq.sv
// Directed bench for lzc_normalizer_seq (W=16, CW=5): results, latency, backpressure, reset.
module tb_lzc_normalizer_seq;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    lzc_normalizer_seq_if #(.W(16), .CW(5)) bus ();

    lzc_normalizer_seq #(.W(16), .CW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a word at a negedge and let the next posedge accept it.
    task automatic send(input logic [15:0] word);
        @(negedge clk);
        check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = word;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 16'h0;
    endtask

    task automatic wait_result(input string tag, input logic [15:0] exp_norm,
                               input logic [4:0] exp_lz, input logic exp_zf, input int exp_lat);
        int n;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.out_valid) break;
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_norm"}, 32'(bus.norm_out), 32'(exp_norm));
        check({tag, "_lz"}, 32'(bus.lz_count), 32'(exp_lz));
        check({tag, "_zf"}, 32'(bus.zero_flag), 32'(exp_zf));
    endtask

    task automatic release_result(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_norm", 32'(bus.norm_out), 32'd0);
        check("rst_lz", 32'(bus.lz_count), 32'd0);
        check("rst_zf", 32'(bus.zero_flag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        send(16'h8000); wait_result("w8000", 16'h8000, 5'd0, 1'b0, 2); release_result("w8000");
        send(16'h0001); wait_result("w0001", 16'h8000, 5'd15, 1'b0, 5); release_result("w0001");
        send(16'h0350); wait_result("w0350", 16'hD400, 5'd6, 1'b0, 3); release_result("w0350");
        send(16'h0000); wait_result("w0000", 16'h0000, 5'd16, 1'b1, 4); release_result("w0000");

        // Backpressure: result must hold and new words must be ignored.
        send(16'h0F00);
        wait_result("w0F00", 16'hF000, 5'd4, 1'b0, 3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 16'h1234;
            @(posedge clk);
            #1;
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_norm", 32'(bus.norm_out), 32'hF000);
            check("bp_lz", 32'(bus.lz_count), 32'd4);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 16'h0;
        release_result("w0F00");
        send(16'h4000); wait_result("w4000", 16'h8000, 5'd1, 1'b0, 2); release_result("w4000");

        // Reset in the middle of a scan discards the operation.
        send(16'h0001);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_norm", 32'(bus.norm_out), 32'd0);
        check("mid_rst_lz", 32'(bus.lz_count), 32'd0);
        check("mid_rst_zf", 32'(bus.zero_flag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        send(16'h2000); wait_result("w2000", 16'h8000, 5'd2, 1'b0, 2); release_result("w2000");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
